// File: rtl/bnn_pkg.sv
// Shared constants, state encoding and sizing helpers for the BNN neuron.
package bnn_pkg;

    localparam int THRESHOLD_WIDTH = 32;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    // Number of beats needed to stream n items p at a time.
    function automatic int ceil_div(input int n, input int p);
        return (n + p - 1) / p;
    endfunction

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int acc_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/neuron_processor_xnor_popcount.sv
// Masked XNOR popcount over one beat of activation/weight bits.
module xnor_popcount
    import bnn_pkg::*;
#(
    parameter int PARALLEL_INPUTS = 1,
    parameter int CW              = acc_width(PARALLEL_INPUTS)
) (
    input  logic [PARALLEL_INPUTS-1:0] a,
    input  logic [PARALLEL_INPUTS-1:0] b,
    input  logic [PARALLEL_INPUTS-1:0] mask,
    output logic [CW-1:0]              cnt
);

    logic [PARALLEL_INPUTS-1:0] w_match;

    // Count lanes where activation equals weight, ignoring masked-off lanes.
    always_comb begin
        w_match = ~(a ^ b) & mask;
        cnt     = '0;
        for (int i = 0; i < PARALLEL_INPUTS; i++) begin
            cnt = cnt + CW'(w_match[i]);
        end
    end

endmodule

// File: rtl/neuron_processor.sv
// Single binary neuron: accumulates XNOR popcount over a streamed vector,
// then compares against a threshold and pulses out_valid for one cycle.
module neuron_processor
    import bnn_pkg::*;
#(
    parameter int       PARALLEL_INPUTS    = 1,
    parameter int       PARALLEL_NEURONS   = 1,
    parameter bit       PARALLELIZE_LAYERS = 1'b0,
    parameter int       NUM_INPUTS         = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PARALLEL_INPUTS-1:0] inputs,
    input  logic [PARALLEL_INPUTS-1:0] weights,
    input  logic [THRESHOLD_WIDTH-1:0] threshold,
    input  logic                       inputs_valid,
    input  logic                       weights_valid,
    output logic                       rd_en,
    output logic                       out_valid,
    output logic                       out
);

    localparam int BEATS      = ceil_div(NUM_INPUTS, PARALLEL_INPUTS);
    localparam int AW         = acc_width(NUM_INPUTS);
    localparam int CW         = acc_width(PARALLEL_INPUTS);
    localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAST_LANES = NUM_INPUTS - (BEATS - 1) * PARALLEL_INPUTS;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    // Only a single neuron per instance exists; the layer hint is ignored here.
    if (PARALLEL_NEURONS != 1 || PARALLELIZE_LAYERS > 1'b1) begin : g_bad_cfg
        $error("neuron_processor supports PARALLEL_NEURONS == 1 only");
    end

    state_t                     r_state;
    state_t                     w_state_next;
    logic [AW-1:0]              r_acc;
    logic [BW-1:0]              r_beat;
    logic                       r_out;
    logic                       w_last;
    logic                       w_accept;
    logic                       w_fire;
    logic [PARALLEL_INPUTS-1:0] w_mask;
    logic [CW-1:0]              w_cnt;
    logic [AW-1:0]              w_acc_next;

    xnor_popcount #(
        .PARALLEL_INPUTS(PARALLEL_INPUTS),
        .CW             (CW)
    ) u_pop (
        .a   (inputs),
        .b   (weights),
        .mask(w_mask),
        .cnt (w_cnt)
    );

    // Lane mask: the final beat only carries LAST_LANES real inputs.
    always_comb begin
        w_last = (r_beat == LAST_BEAT);
        w_mask = '1;
        for (int i = 0; i < PARALLEL_INPUTS; i++) begin
            w_mask[i] = !w_last || (i < LAST_LANES);
        end
    end

    // Popcount of a masked beat never exceeds NUM_INPUTS, so the resize is lossless.
    assign w_acc_next = r_acc + AW'(w_cnt);
    assign w_fire     = (THRESHOLD_WIDTH'(w_acc_next) >= threshold);
    assign w_accept   = inputs_valid && weights_valid && rd_en;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_ACCUM;
        else     r_state <= w_state_next;
    end

    // Next state and handshake outputs; rd_en is held low while in reset.
    always_comb begin
        w_state_next = r_state;
        rd_en        = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                rd_en = !rst;
                if (w_accept && w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid    = !rst;
                w_state_next = ST_ACCUM;
            end
            default: w_state_next = ST_ACCUM;
        endcase
    end

    // Accumulator, beat counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_beat <= '0;
            r_out  <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_acc  <= '0;
            r_beat <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            if (w_last) r_out  <= w_fire;
            else        r_beat <= r_beat + BW'(1);
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_neuron_processor.sv
// Scoreboard bench: two neuron configurations (PI=1/NI=2 and PI=4/NI=10).
module tb_neuron_processor;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:0]  in0, w0;
    logic [3:0]  in1, w1;
    logic [31:0] thr0, thr1;
    logic        iv0, wv0, iv1, wv1;
    logic        rd0, ov0, out0, rd1, ov1, out1;

    int total = 0;
    int bad   = 0;
    bit q0[$];
    bit q1[$];

    always #5 clk = ~clk;

    neuron_processor #(
        .PARALLEL_INPUTS(1), .PARALLEL_NEURONS(1), .PARALLELIZE_LAYERS(1'b0), .NUM_INPUTS(2)
    ) u0 (
        .clk(clk), .rst(rst), .inputs(in0), .weights(w0), .threshold(thr0),
        .inputs_valid(iv0), .weights_valid(wv0), .rd_en(rd0), .out_valid(ov0), .out(out0)
    );

    neuron_processor #(
        .PARALLEL_INPUTS(4), .PARALLEL_NEURONS(1), .PARALLELIZE_LAYERS(1'b0), .NUM_INPUTS(10)
    ) u1 (
        .clk(clk), .rst(rst), .inputs(in1), .weights(w1), .threshold(thr1),
        .inputs_valid(iv1), .weights_valid(wv1), .rd_en(rd1), .out_valid(ov1), .out(out1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitors: pop the expected result whenever a neuron presents one.
    always @(negedge clk) begin
        if (ov0 === 1'b1) begin
            if (q0.size() == 0) chk("u0_unexpected_valid", 1, 0);
            else chk("u0_out", {31'b0, out0}, {31'b0, q0.pop_front()});
            chk("u0_rd_en_in_done", {31'b0, rd0}, 0);
        end
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) chk("u1_unexpected_valid", 1, 0);
            else chk("u1_out", {31'b0, out1}, {31'b0, q1.pop_front()});
            chk("u1_rd_en_in_done", {31'b0, rd1}, 0);
        end
    end

    // Present one beat (valids left high) and wait for the edge that takes it.
    task automatic send0(input logic i, input logic w);
        int n = 0;
        in0 = i; w0 = w; iv0 = 1'b1; wv0 = 1'b1;
        while (rd0 !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("u0_rd_en_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic send1(input logic [3:0] i, input logic [3:0] w);
        int n = 0;
        in1 = i; w1 = w; iv1 = 1'b1; wv1 = 1'b1;
        while (rd1 !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("u1_rd_en_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int cycles);
        iv0 = 1'b0; wv0 = 1'b0; iv1 = 1'b0; wv1 = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in0 = '0; w0 = '0; in1 = '0; w1 = '0;
        iv0 = 1'b0; wv0 = 1'b0; iv1 = 1'b0; wv1 = 1'b0;
        thr0 = 32'd2; thr1 = 32'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", {31'b0, rd0}, 0);
        chk("rst_out_valid", {31'b0, ov0}, 0);
        chk("rst_out", {31'b0, out0}, 0);
        chk("rst_rd_en_u1", {31'b0, rd1}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_rd_en", {31'b0, rd0}, 1);

        // popcount 1 < 2
        thr0 = 2; q0.push_back(1'b0);
        send0(1, 1); send0(0, 1);
        chk("done_rd_en_low", {31'b0, rd0}, 0);
        idle(2);

        // popcount 2 == threshold fires
        q0.push_back(1'b1);
        send0(1, 1); send0(0, 0);
        idle(3);
        chk("out_holds", {31'b0, out0}, 1);

        // Only one valid high for 3 cycles: matching data must not count
        q0.push_back(1'b0);
        send0(1, 1);
        in0 = 1; w0 = 1; iv0 = 1'b1; wv0 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        send0(0, 1);
        idle(2);

        // Threshold 0 always fires, threshold above NUM_INPUTS never does
        thr0 = 0; q0.push_back(1'b1);
        send0(1, 0); send0(0, 1);
        idle(2);
        thr0 = 3; q0.push_back(1'b0);
        send0(1, 1); send0(0, 0);
        idle(2);

        // Back-to-back passes with valids held high
        thr0 = 2; q0.push_back(1'b1); q0.push_back(1'b0);
        send0(1, 1); send0(1, 1);
        chk("b2b_done_rd_en", {31'b0, rd0}, 0);
        in0 = 1; w0 = 0;
        @(posedge clk); #1;
        chk("b2b_restart_rd_en", {31'b0, rd0}, 1);
        send0(1, 0); send0(0, 1);
        idle(2);

        // Abort mid-pass; leftover count would wrongly make the next pass fire
        send0(1, 1);
        iv0 = 1'b0; wv0 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_rd_en_in_rst", {31'b0, rd0}, 0);
        rst = 1'b0;
        #1;
        chk("abort_rd_en_after", {31'b0, rd0}, 1);
        q0.push_back(1'b0);
        send0(0, 1); send0(1, 1);
        idle(2);

        // Wide config: lanes 2-3 of beat 3 are padding
        thr1 = 9; q1.push_back(1'b1);
        send1(4'b1010, 4'b1010); send1(4'b0110, 4'b0110); send1(4'b1101, 4'b0001);
        idle(2);
        thr1 = 11; q1.push_back(1'b0);
        send1(4'b1111, 4'b1111); send1(4'b0000, 4'b0000); send1(4'b1111, 4'b1111);
        idle(2);
        thr1 = 9; q1.push_back(1'b1);
        send1(4'b0011, 4'b0011); send1(4'b1100, 4'b1100); send1(4'b0001, 4'b1100);
        idle(2);
        thr1 = 10; q1.push_back(1'b0);
        send1(4'b0011, 4'b0011); send1(4'b1100, 4'b1100); send1(4'b0001, 4'b1100);
        idle(5);

        chk("u0_queue_drained", q0.size(), 0);
        chk("u1_queue_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
